_logic_unit_arbiter: RTL and testbench
======================================

// Module: _logic_unit_arbiter
// PURPOSE
//  Shares one W-bit bitwise logic unit (AND/OR/XOR/XNOR/NAND/NOR/INV/PASS) among 4 requesters.
//  Round-robin arbitration accepts at most one request per cycle. A 2-stage pipeline
//  (operand register, result register) returns each result tagged with the requester id.
//  Sits between requesting controllers and the 32-bit gate datapath.
// PARAMETERS
//  W   32  operand/result width in bits (>=1); requester count fixed at 4, id width fixed at 2
// PORTS
//  clk        in   1     rising-edge clock
//  reset      in   1     synchronous, active-high reset
//  req        in   4     req[i]=1: requester i has a valid op; held until gnt[i]
//  op         in   12    op[3i+2:3i] opcode of requester i
//  a          in   4*W   a[W*i+W-1:W*i] operand A of requester i
//  b          in   4*W   b[W*i+W-1:W*i] operand B of requester i
//  gnt        out  4     one-hot/zero, combinational; gnt[i]=1 means op accepted at this edge
//  res_valid  out  1     registered; 1-cycle pulse per accepted op
//  res_id     out  2     registered; index of requester owning res_data
//  res_data   out  W     registered result
//  res_zero   out  1     registered; 1 iff res_data==0
// BEHAVIOUR
//  Opcodes: 000 a&b, 001 a|b, 010 a^b, 011 ~(a^b), 100 ~(a&b), 101 ~(a|b), 110 ~a, 111 a.
//  Arbitration:
//   - ptr[1:0] holds the last granted index.
//   - Search order: ptr+1, ptr+2, ptr+3, ptr, mod 4.
//   - The first requester with req=1 in that order gets gnt; gnt=0 when req=0.
//   - gnt is forced to 0 while reset=1.
//   - ptr updates to the granted index on an accepting edge; otherwise it holds.
//  Pipeline:
//   - Edge k (gnt[i]=1): capture op/a/b of requester i, id=i, and s1_valid=1 into stage 1.
//     If no gnt, s1_valid=0.
//   - Edge k+1: stage 1 is computed combinationally; res_data, res_id, res_zero and
//     res_valid<=s1_valid are registered.
//   - Latency: res_valid is high during the cycle after edge k+1 (2 edges after acceptance).
//   - Throughput is 1 op/cycle, no stalls, no backpressure. Consumers must take results
//     when res_valid=1.
//   - A requester may re-request in the cycle after its grant. It is then eligible again,
//     but only wins if no other requester is pending.
//  Reset (sync, reset=1 at an edge):
//   - ptr<=3, so requester 0 has first priority.
//   - s1_valid<=0, stage-1 data<=0.
//   - res_valid<=0, res_id<=0, res_data<=0, res_zero<=0.
//  Boundaries:
//   - Reset mid-operation discards every in-flight op; no res_valid ever appears for it.
//   - Wrap-around: after a grant to 3, the search restarts at 0.
//   - A single persistent requester is granted every cycle.
//   - req changing in a cycle without gnt has no effect on state.
//   - res_valid and a new gnt in the same cycle are independent; both occur.
//   - Opcodes 110/111 ignore b.
// TESTING
//  1. Hold reset 2 cycles -> all registered outputs 0. Release with req=4'b1111 -> first gnt=4'b0001.
//  2. req=4'b0010, op1=000, a1=32'hF0F0_F0F0, b1=32'hFF00_FF00 -> gnt=0010.
//     Two edges later: res_valid=1, res_id=1, res_data=32'hF000_F000, res_zero=0.
//  3. req=4'b1111 held 5 cycles -> gnt 0001,0010,0100,1000,0001.
//     res_valid high for 5 consecutive cycles with ids 0,1,2,3,0.
//  4. After a grant to 0, req=4'b0101 -> gnt=0100; then only req0 -> gnt=0001 (wrap via 3).
//  5. op=010, a=b=32'hA5A5_A5A5 -> res_data=0, res_zero=1.
//     op=110, a=0 -> res_data=32'hFFFF_FFFF, res_zero=0.
//  6. Grant to 2, then reset=1 on the next edge -> res_valid stays 0.
//     After release with req=4'b1111 -> gnt=0001.

Source files
------------

// File: rtl/_logic_unit_arbiter.sv
// Round-robin arbiter sharing one W-bit bitwise logic unit among 4 requesters.
// Two-stage pipeline: operand register, then result register tagged with the requester id.
module _logic_unit_arbiter #(
    parameter int unsigned W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [11:0]      op,
    input  logic [4*W-1:0]   a,
    input  logic [4*W-1:0]   b,
    output logic [3:0]       gnt,
    output logic             res_valid,
    output logic [1:0]       res_id,
    output logic [W-1:0]     res_data,
    output logic             res_zero
);

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OP_AND  = 3'b000;
    localparam logic [OPW-1:0] OP_OR   = 3'b001;
    localparam logic [OPW-1:0] OP_XOR  = 3'b010;
    localparam logic [OPW-1:0] OP_XNOR = 3'b011;
    localparam logic [OPW-1:0] OP_NAND = 3'b100;
    localparam logic [OPW-1:0] OP_NOR  = 3'b101;
    localparam logic [OPW-1:0] OP_INV  = 3'b110;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [IDW-1:0] id;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
    } s1_t;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] srch_idx;
    logic           gnt_any;
    logic           s1_valid;
    s1_t            s1;
    s1_t            s1_next;
    logic [W-1:0]   result_c;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        srch_idx = '0;
        gnt_any  = 1'b0;
        if (!reset) begin
            for (int unsigned k = 1; k <= N; k++) begin
                srch_idx = ptr + IDW'(k);
                if (!gnt_any && req[srch_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = srch_idx;
                end
            end
            if (gnt_any) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        s1_next    = '0;
        s1_next.op = op[OPW*gnt_idx +: OPW];
        s1_next.id = gnt_idx;
        s1_next.a  = a[W*gnt_idx +: W];
        s1_next.b  = b[W*gnt_idx +: W];
    end

    // Shared bitwise logic unit.
    always_comb begin
        result_c = '0;
        case (s1.op)
            OP_AND:  result_c = s1.a & s1.b;
            OP_OR:   result_c = s1.a | s1.b;
            OP_XOR:  result_c = s1.a ^ s1.b;
            OP_XNOR: result_c = ~(s1.a ^ s1.b);
            OP_NAND: result_c = ~(s1.a & s1.b);
            OP_NOR:  result_c = ~(s1.a | s1.b);
            OP_INV:  result_c = ~s1.a;
            default: result_c = s1.a;
        endcase
    end

    // Pointer, operand stage and result stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= IDW'(N - 1);
            s1_valid  <= 1'b0;
            s1        <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            res_zero  <= 1'b0;
        end else begin
            s1_valid  <= gnt_any;
            res_valid <= s1_valid;
            if (gnt_any) begin
                ptr <= gnt_idx;
                s1  <= s1_next;
            end
            if (s1_valid) begin
                res_id   <= s1.id;
                res_data <= result_c;
                res_zero <= (result_c == '0);
            end
        end
    end

endmodule

// File: tb/tb__logic_unit_arbiter.sv
// Directed bench for _logic_unit_arbiter: arbitration order, pipeline latency,
// opcode results, wrap-around and reset flush.
module tb__logic_unit_arbiter;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     req;
    logic [11:0]    op;
    logic [4*W-1:0] a;
    logic [4*W-1:0] b;
    logic [3:0]     gnt;
    logic           res_valid;
    logic [1:0]     res_id;
    logic [W-1:0]   res_data;
    logic           res_zero;

    int passed = 0;
    int total  = 0;

    _logic_unit_arbiter #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .a         (a),
        .b         (b),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .res_zero  (res_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        op    = '0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        total++;
        if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %0b want 0", res_valid); else passed++;
        total++;
        if (res_id !== 2'd0) $display("FAIL reset_res_id got %0d want 0", res_id); else passed++;
        total++;
        if (res_data !== 32'h0) $display("FAIL reset_res_data got %h want 0", res_data); else passed++;
        total++;
        if (res_zero !== 1'b0) $display("FAIL reset_res_zero got %0b want 0", res_zero); else passed++;
        total++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt_forced got %b want 0000", gnt); else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (gnt !== 4'b0001) $display("FAIL reset_first_gnt got %b want 0001", gnt); else passed++;
        req = '0;
        tick();
        tick();
        tick();
        total++;
        if (res_valid !== 1'b0) $display("FAIL reset_no_stray_valid got %0b want 0", res_valid); else passed++;
    endtask

    task automatic test_single_op();
        req        = 4'b0010;
        op[5:3]    = 3'b000;
        a[63:32]   = 32'hF0F0_F0F0;
        b[63:32]   = 32'hFF00_FF00;
        #1;
        total++;
        if (gnt !== 4'b0010) $display("FAIL single_gnt got %b want 0010", gnt); else passed++;
        tick();
        req = '0;
        total++;
        if (res_valid !== 1'b0) $display("FAIL single_early_valid got %0b want 0", res_valid); else passed++;
        tick();
        total++;
        if (res_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", res_valid); else passed++;
        total++;
        if (res_id !== 2'd1) $display("FAIL single_id got %0d want 1", res_id); else passed++;
        total++;
        if (res_data !== 32'hF000_F000) $display("FAIL single_data got %h want f000f000", res_data); else passed++;
        total++;
        if (res_zero !== 1'b0) $display("FAIL single_zero got %0b want 0", res_zero); else passed++;
        tick();
        total++;
        if (res_valid !== 1'b0) $display("FAIL single_pulse got %0b want 0", res_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0]  exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [31:0] vals    [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            op[3*i +: 3] = 3'b111;
            a[W*i +: W]  = vals[i];
            b[W*i +: W]  = 32'hDEAD_BEEF;
        end
        for (int c = 0; c < 7; c++) begin
            if (c >= 2) begin
                total++;
                if (res_valid !== 1'b1) $display("FAIL b2b_valid c=%0d got %0b want 1", c, res_valid); else passed++;
                total++;
                if (res_id !== exp_id[c-2]) $display("FAIL b2b_id c=%0d got %0d want %0d", c, res_id, exp_id[c-2]); else passed++;
                total++;
                if (res_data !== vals[exp_id[c-2]]) $display("FAIL b2b_data c=%0d got %h want %h", c, res_data, vals[exp_id[c-2]]); else passed++;
            end else begin
                total++;
                if (res_valid !== 1'b0) $display("FAIL b2b_idle c=%0d got %0b want 0", c, res_valid); else passed++;
            end
            req = (c < 5) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 5) begin
                total++;
                if (gnt !== exp_gnt[c]) $display("FAIL b2b_gnt c=%0d got %b want %b", c, gnt, exp_gnt[c]); else passed++;
            end
            tick();
        end
        total++;
        if (res_valid !== 1'b0) $display("FAIL b2b_tail got %0b want 0", res_valid); else passed++;
    endtask

    task automatic test_wrap();
        // Last grant was to requester 0.
        req = 4'b0101;
        #1;
        total++;
        if (gnt !== 4'b0100) $display("FAIL wrap_skip got %b want 0100", gnt); else passed++;
        tick();
        req = 4'b0001;
        #1;
        total++;
        if (gnt !== 4'b0001) $display("FAIL wrap_around got %b want 0001", gnt); else passed++;
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (gnt !== 4'b0001) $display("FAIL wrap_persistent c=%0d got %b want 0001", c, gnt); else passed++;
            tick();
        end
        req = 4'b1000;
        #1;
        total++;
        if (gnt !== 4'b1000) $display("FAIL wrap_to3 got %b want 1000", gnt); else passed++;
        tick();
        req = 4'b1111;
        #1;
        total++;
        if (gnt !== 4'b0001) $display("FAIL wrap_after3 got %b want 0001", gnt); else passed++;
        req = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_opcodes();
        logic [31:0] exp_res [8] = '{32'hFF00_0000, 32'hFFFF_FF00, 32'h00FF_FF00, 32'hFF00_00FF,
                                     32'h00FF_FFFF, 32'h0000_00FF, 32'h0000_FFFF, 32'hFFFF_0000};
        a[W*2 +: W] = 32'hFFFF_0000;
        b[W*2 +: W] = 32'hFF00_FF00;
        for (int c = 0; c < 10; c++) begin
            if (c >= 2) begin
                total++;
                if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== exp_res[c-2])
                    $display("FAIL opcode_%0d got v=%0b id=%0d data=%h want v=1 id=2 data=%h",
                             c-2, res_valid, res_id, res_data, exp_res[c-2]);
                else passed++;
            end
            req       = (c < 8) ? 4'b0100 : 4'b0000;
            op[8:6]   = 3'(c);
            tick();
        end
        // XOR of equal operands gives zero; INV of zero gives all ones regardless of b.
        req         = 4'b0100;
        op[8:6]     = 3'b010;
        a[W*2 +: W] = 32'hA5A5_A5A5;
        b[W*2 +: W] = 32'hA5A5_A5A5;
        tick();
        op[8:6]     = 3'b110;
        a[W*2 +: W] = 32'h0;
        b[W*2 +: W] = 32'h1234_5678;
        tick();
        req = '0;
        total++;
        if (res_data !== 32'h0 || res_zero !== 1'b1 || res_valid !== 1'b1)
            $display("FAIL xor_zero got v=%0b data=%h zero=%0b want v=1 data=0 zero=1", res_valid, res_data, res_zero);
        else passed++;
        tick();
        total++;
        if (res_data !== 32'hFFFF_FFFF || res_zero !== 1'b0 || res_valid !== 1'b1)
            $display("FAIL inv_ones got v=%0b data=%h zero=%0b want v=1 data=ffffffff zero=0", res_valid, res_data, res_zero);
        else passed++;
        tick();
    endtask

    task automatic test_reset_flush();
        do_reset();
        req = 4'b0100;
        #1;
        total++;
        if (gnt !== 4'b0100) $display("FAIL flush_gnt2 got %b want 0100", gnt); else passed++;
        tick();
        reset = 1'b1;
        req   = '0;
        tick();
        total++;
        if (res_valid !== 1'b0) $display("FAIL flush_valid0 got %0b want 0", res_valid); else passed++;
        tick();
        total++;
        if (res_valid !== 1'b0) $display("FAIL flush_valid1 got %0b want 0", res_valid); else passed++;
        reset = 1'b0;
        req   = 4'b1111;
        #1;
        total++;
        if (gnt !== 4'b0001) $display("FAIL flush_restart got %b want 0001", gnt); else passed++;
        req = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (res_valid !== 1'b0) $display("FAIL flush_quiet c=%0d got %0b want 0", c, res_valid); else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        op    = '0;
        a     = '0;
        b     = '0;
        #1;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_wrap();
        test_opcodes();
        test_reset_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
